// File: rtl/riscv_decode_stage_pkg.sv
// riscv_decode_stage_pkg: decode enums, control word layout, instruction encodings and builders
package riscv_decode_stage_pkg;
  localparam int XLEN = 32;
  typedef enum logic [4:0] {
    ALU_X, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_COPY2, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } exec_fun_e;
  typedef enum logic [1:0] {OP1_X, OP1_RS1, OP1_PC} op1_sel_e;
  typedef enum logic [2:0] {OP2_X, OP2_RS2, OP2_IMI, OP2_IMS, OP2_IMB, OP2_IMU, OP2_IMJ} op2_sel_e;
  typedef enum logic [1:0] {WB_X, WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
  typedef enum logic {RF_X, RF_WRITE} rf_wen_e;
  typedef enum logic {MEM_X, MEM_WRITE} mem_wen_e;
  typedef enum logic [1:0] {PC_PLUS4, PC_B_TARGET, PC_J_TARGET, PC_JALR} pc_sel_e;
  typedef enum logic [2:0] {MASK_X, MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU} mask_sel_e;
  typedef struct packed {
    exec_fun_e exec_fun;
    op1_sel_e  op1_sel;
    op2_sel_e  op2_sel;
    wb_sel_e   wb_sel;
    rf_wen_e   rf_wen;
    mem_wen_e  mem_wen;
    pc_sel_e   pc_sel;
    mask_sel_e rs2_mask_sel;
    mask_sel_e ram_mask_sel;
  } ctrl_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    ctrl_t           ctrl;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            ill;
  } dec_t;
  localparam ctrl_t CTRL_DEF = '{ALU_X, OP1_X, OP2_X, WB_X, RF_X, MEM_X, PC_PLUS4, MASK_X, MASK_X};
  localparam dec_t DEC_DEF = '{32'd0, CTRL_DEF, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0};
  localparam logic [31:0] INST_R_MASK = 32'hFE00707F;
  localparam logic [31:0] INST_I_MASK = 32'h0000707F;
  localparam logic [31:0] INST_U_MASK = 32'h0000007F;
  localparam logic [31:0] INST_ADD = 32'h00000033, INST_SUB = 32'h40000033, INST_SLL = 32'h00001033;
  localparam logic [31:0] INST_SLT = 32'h00002033, INST_SLTU = 32'h00003033, INST_XOR = 32'h00004033;
  localparam logic [31:0] INST_SRL = 32'h00005033, INST_SRA = 32'h40005033, INST_OR = 32'h00006033;
  localparam logic [31:0] INST_AND = 32'h00007033;
  localparam logic [31:0] INST_ADDI = 32'h00000013, INST_SLTI = 32'h00002013, INST_SLTIU = 32'h00003013;
  localparam logic [31:0] INST_XORI = 32'h00004013, INST_ORI = 32'h00006013, INST_ANDI = 32'h00007013;
  localparam logic [31:0] INST_SLLI = 32'h00001013, INST_SRLI = 32'h00005013, INST_SRAI = 32'h40005013;
  localparam logic [31:0] INST_LB = 32'h00000003, INST_LH = 32'h00001003, INST_LW = 32'h00002003;
  localparam logic [31:0] INST_LBU = 32'h00004003, INST_LHU = 32'h00005003;
  localparam logic [31:0] INST_SB = 32'h00000023, INST_SH = 32'h00001023, INST_SW = 32'h00002023;
  localparam logic [31:0] INST_JAL = 32'h0000006F, INST_JALR = 32'h00000067;
  localparam logic [31:0] INST_BEQ = 32'h00000063, INST_BNE = 32'h00001063, INST_BLT = 32'h00004063;
  localparam logic [31:0] INST_BGE = 32'h00005063, INST_BLTU = 32'h00006063, INST_BGEU = 32'h00007063;
  localparam logic [31:0] INST_LUI = 32'h00000037, INST_AUIPC = 32'h00000017;
  localparam logic [31:0] INST_MUL = 32'h02000033, INST_MULH = 32'h02001033, INST_MULHSU = 32'h02002033;
  localparam logic [31:0] INST_MULHU = 32'h02003033, INST_DIV = 32'h02004033, INST_DIVU = 32'h02005033;
  localparam logic [31:0] INST_REM = 32'h02006033, INST_REMU = 32'h02007033;
  function automatic logic hit(input logic [31:0] i, input logic [31:0] m, input logic [31:0] v);
    return (i & m) == v;
  endfunction
  function automatic ctrl_t alu(input exec_fun_e f, input op1_sel_e a, input op2_sel_e b);
    return '{f, a, b, WB_ALU, RF_WRITE, MEM_X, PC_PLUS4, MASK_X, MASK_X};
  endfunction
  function automatic ctrl_t ld(input mask_sel_e m);
    return '{ALU_ADD, OP1_RS1, OP2_IMI, WB_MEM, RF_WRITE, MEM_X, PC_PLUS4, MASK_X, m};
  endfunction
  function automatic ctrl_t st(input mask_sel_e m);
    return '{ALU_ADD, OP1_RS1, OP2_IMS, WB_X, RF_X, MEM_WRITE, PC_PLUS4, m, m};
  endfunction
  function automatic ctrl_t br(input exec_fun_e f);
    return '{f, OP1_RS1, OP2_IMB, WB_X, RF_X, MEM_X, PC_B_TARGET, MASK_X, MASK_X};
  endfunction
endpackage

// File: rtl/riscv_decode_stage_if.sv
// riscv_decode_stage_if: fetch-side input and decoded-side output bundle of the decode stage
interface riscv_decode_stage_if #(parameter int W = 32, parameter int CW = 16);
  import riscv_decode_stage_pkg::*;
  logic flush_i, valid_i, ready_o, valid_o, ready_i, illegal_o;
  logic [W-1:0] pc_i, inst_i, pc_o, imm_o;
  logic [4:0] rs1_o, rs2_o, rd_o;
  exec_fun_e exec_fun;
  op1_sel_e op1_sel;
  op2_sel_e op2_sel;
  wb_sel_e wb_sel;
  rf_wen_e rf_wen;
  mem_wen_e mem_wen;
  pc_sel_e pc_sel;
  mask_sel_e rs2_mask_sel, ram_mask_sel;
  logic [CW-1:0] illegal_cnt_o;
  modport slave (
    input flush_i, valid_i, pc_i, inst_i, ready_i,
    output ready_o, valid_o, pc_o, rs1_o, rs2_o, rd_o, imm_o, exec_fun, op1_sel, op2_sel, wb_sel,
    rf_wen, mem_wen, pc_sel, rs2_mask_sel, ram_mask_sel, illegal_o, illegal_cnt_o
  );
  modport master (
    output flush_i, valid_i, pc_i, inst_i, ready_i,
    input ready_o, valid_o, pc_o, rs1_o, rs2_o, rd_o, imm_o, exec_fun, op1_sel, op2_sel, wb_sel,
    rf_wen, mem_wen, pc_sel, rs2_mask_sel, ram_mask_sel, illegal_o, illegal_cnt_o
  );
endinterface

// File: rtl/riscv_decode_comb.sv
// riscv_decode_comb: combinational decode of one instruction into a full decoded word
module riscv_decode_comb import riscv_decode_stage_pkg::*; #(
  parameter int ENABLE_M = 0
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  output dec_t            dec_o
);
  localparam logic M = (ENABLE_M != 0);
  ctrl_t c;
  logic ill;
  logic [XLEN-1:0] imm;
  // Priority match: M (when enabled), R, I, shift-imm, load, S, J, B, U; anything else is illegal
  always_comb begin
    c = CTRL_DEF;
    ill = 1'b0;
    if (M && hit(inst_i, INST_R_MASK, INST_MUL)) c = alu(ALU_MUL, OP1_RS1, OP2_RS2);
    else if (M && hit(inst_i, INST_R_MASK, INST_MULH)) c = alu(ALU_MULH, OP1_RS1, OP2_RS2);
    else if (M && hit(inst_i, INST_R_MASK, INST_MULHSU)) c = alu(ALU_MULHSU, OP1_RS1, OP2_RS2);
    else if (M && hit(inst_i, INST_R_MASK, INST_MULHU)) c = alu(ALU_MULHU, OP1_RS1, OP2_RS2);
    else if (M && hit(inst_i, INST_R_MASK, INST_DIV)) c = alu(ALU_DIV, OP1_RS1, OP2_RS2);
    else if (M && hit(inst_i, INST_R_MASK, INST_DIVU)) c = alu(ALU_DIVU, OP1_RS1, OP2_RS2);
    else if (M && hit(inst_i, INST_R_MASK, INST_REM)) c = alu(ALU_REM, OP1_RS1, OP2_RS2);
    else if (M && hit(inst_i, INST_R_MASK, INST_REMU)) c = alu(ALU_REMU, OP1_RS1, OP2_RS2);
    else if (hit(inst_i, INST_R_MASK, INST_ADD)) c = alu(ALU_ADD, OP1_RS1, OP2_RS2);
    else if (hit(inst_i, INST_R_MASK, INST_SUB)) c = alu(ALU_SUB, OP1_RS1, OP2_RS2);
    else if (hit(inst_i, INST_R_MASK, INST_SLL)) c = alu(ALU_SLL, OP1_RS1, OP2_RS2);
    else if (hit(inst_i, INST_R_MASK, INST_SLT)) c = alu(ALU_SLT, OP1_RS1, OP2_RS2);
    else if (hit(inst_i, INST_R_MASK, INST_SLTU)) c = alu(ALU_SLTU, OP1_RS1, OP2_RS2);
    else if (hit(inst_i, INST_R_MASK, INST_XOR)) c = alu(ALU_XOR, OP1_RS1, OP2_RS2);
    else if (hit(inst_i, INST_R_MASK, INST_SRL)) c = alu(ALU_SRL, OP1_RS1, OP2_RS2);
    else if (hit(inst_i, INST_R_MASK, INST_SRA)) c = alu(ALU_SRA, OP1_RS1, OP2_RS2);
    else if (hit(inst_i, INST_R_MASK, INST_OR)) c = alu(ALU_OR, OP1_RS1, OP2_RS2);
    else if (hit(inst_i, INST_R_MASK, INST_AND)) c = alu(ALU_AND, OP1_RS1, OP2_RS2);
    else if (hit(inst_i, INST_I_MASK, INST_ADDI)) c = alu(ALU_ADD, OP1_RS1, OP2_IMI);
    else if (hit(inst_i, INST_I_MASK, INST_SLTI)) c = alu(ALU_SLT, OP1_RS1, OP2_IMI);
    else if (hit(inst_i, INST_I_MASK, INST_SLTIU)) c = alu(ALU_SLTU, OP1_RS1, OP2_IMI);
    else if (hit(inst_i, INST_I_MASK, INST_XORI)) c = alu(ALU_XOR, OP1_RS1, OP2_IMI);
    else if (hit(inst_i, INST_I_MASK, INST_ORI)) c = alu(ALU_OR, OP1_RS1, OP2_IMI);
    else if (hit(inst_i, INST_I_MASK, INST_ANDI)) c = alu(ALU_AND, OP1_RS1, OP2_IMI);
    else if (hit(inst_i, INST_R_MASK, INST_SLLI)) c = alu(ALU_SLL, OP1_RS1, OP2_IMI);
    else if (hit(inst_i, INST_R_MASK, INST_SRLI)) c = alu(ALU_SRL, OP1_RS1, OP2_IMI);
    else if (hit(inst_i, INST_R_MASK, INST_SRAI)) c = alu(ALU_SRA, OP1_RS1, OP2_IMI);
    else if (hit(inst_i, INST_I_MASK, INST_LB)) c = ld(MASK_B);
    else if (hit(inst_i, INST_I_MASK, INST_LH)) c = ld(MASK_H);
    else if (hit(inst_i, INST_I_MASK, INST_LW)) c = ld(MASK_W);
    else if (hit(inst_i, INST_I_MASK, INST_LBU)) c = ld(MASK_BU);
    else if (hit(inst_i, INST_I_MASK, INST_LHU)) c = ld(MASK_HU);
    else if (hit(inst_i, INST_I_MASK, INST_SB)) c = st(MASK_B);
    else if (hit(inst_i, INST_I_MASK, INST_SH)) c = st(MASK_H);
    else if (hit(inst_i, INST_I_MASK, INST_SW)) c = st(MASK_W);
    else if (hit(inst_i, INST_U_MASK, INST_JAL)) c = '{ALU_ADD, OP1_PC, OP2_IMJ, WB_PC4, RF_WRITE, MEM_X, PC_J_TARGET, MASK_X, MASK_X};
    else if (hit(inst_i, INST_I_MASK, INST_JALR)) c = '{ALU_ADD, OP1_RS1, OP2_IMI, WB_PC4, RF_WRITE, MEM_X, PC_JALR, MASK_X, MASK_X};
    else if (hit(inst_i, INST_I_MASK, INST_BEQ)) c = br(ALU_BEQ);
    else if (hit(inst_i, INST_I_MASK, INST_BNE)) c = br(ALU_BNE);
    else if (hit(inst_i, INST_I_MASK, INST_BLT)) c = br(ALU_BLT);
    else if (hit(inst_i, INST_I_MASK, INST_BGE)) c = br(ALU_BGE);
    else if (hit(inst_i, INST_I_MASK, INST_BLTU)) c = br(ALU_BLTU);
    else if (hit(inst_i, INST_I_MASK, INST_BGEU)) c = br(ALU_BGEU);
    else if (hit(inst_i, INST_U_MASK, INST_LUI)) c = alu(ALU_COPY2, OP1_X, OP2_IMU);
    else if (hit(inst_i, INST_U_MASK, INST_AUIPC)) c = alu(ALU_ADD, OP1_PC, OP2_IMU);
    else ill = 1'b1;
  end
  // Immediate follows the operand-2 selection so illegal and register-only beats carry zero
  always_comb begin
    imm = c.op2_sel == OP2_IMI ? {{20{inst_i[31]}}, inst_i[31:20]} :
          c.op2_sel == OP2_IMS ? {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]} :
          c.op2_sel == OP2_IMB ? {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0} :
          c.op2_sel == OP2_IMU ? {inst_i[31:12], 12'd0} :
          c.op2_sel == OP2_IMJ ? {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0} :
          '0;
  end
  assign dec_o = '{pc_i, c, imm, inst_i[19:15], inst_i[24:20], inst_i[11:7], ill};
endmodule

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: registered decode stage with 2-entry skid buffer and illegal-beat counter
module riscv_decode_stage import riscv_decode_stage_pkg::*; #(
  parameter int WORD_LENGTH = 32,
  parameter int ENABLE_M = 0,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  riscv_decode_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  state_e state_q, state_d;
  dec_t dec, main_q, main_d, skid_q, skid_d;
  logic valid_q, valid_d, ready_q, ready_d, acc, emit;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WORD_LENGTH-1:0] pc_in, inst_in;
  assign pc_in = bus.pc_i;
  assign inst_in = bus.inst_i;
  riscv_decode_comb #(.ENABLE_M(ENABLE_M)) u_dec (.pc_i(pc_in), .inst_i(inst_in), .dec_o(dec));
  // Handshake, next state and register loads; flush discards an incoming beat and empties the stage
  always_comb begin
    acc = bus.valid_i && ready_q && !bus.flush_i;
    emit = valid_q && bus.ready_i;
    state_d = state_q;
    case (state_q)
      EMPTY: if (acc) state_d = ONE;
      ONE: if (acc && !emit) state_d = TWO; else if (emit && !acc) state_d = EMPTY;
      default: if (emit) state_d = ONE;
    endcase
    if (bus.flush_i) state_d = EMPTY;
    main_d = (acc && (state_q == EMPTY || emit)) ? dec : (state_q == TWO && emit) ? skid_q : main_q;
    skid_d = (acc && state_q == ONE && !emit) ? dec : skid_q;
    valid_d = state_d != EMPTY;
    ready_d = state_d != TWO;
    cnt_d = (acc && dec.ill && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  // State, output registers and saturating counter; counter survives flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q <= DEC_DEF;
      skid_q <= DEC_DEF;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      main_q <= main_d;
      skid_q <= skid_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.pc_o = main_q.pc;
  assign bus.imm_o = main_q.imm;
  assign bus.rs1_o = main_q.rs1;
  assign bus.rs2_o = main_q.rs2;
  assign bus.rd_o = main_q.rd;
  assign bus.exec_fun = main_q.ctrl.exec_fun;
  assign bus.op1_sel = main_q.ctrl.op1_sel;
  assign bus.op2_sel = main_q.ctrl.op2_sel;
  assign bus.wb_sel = main_q.ctrl.wb_sel;
  assign bus.rf_wen = main_q.ctrl.rf_wen;
  assign bus.mem_wen = main_q.ctrl.mem_wen;
  assign bus.pc_sel = main_q.ctrl.pc_sel;
  assign bus.rs2_mask_sel = main_q.ctrl.rs2_mask_sel;
  assign bus.ram_mask_sel = main_q.ctrl.ram_mask_sel;
  assign bus.illegal_o = main_q.ill;
  assign bus.illegal_cnt_o = cnt_q;
endmodule
